fft_frame_sched: RTL and testbench

- Frame scheduler in front of the 64-point pipelined radix-2 FFT core.
- Accepts an arbitrary, gappy valid/ready sample stream and collects samples into a two-bank ping-pong buffer.
- Issues each full bank to the core as one contiguous burst of 2^NALL cycles, with a guaranteed idle gap between bursts so the core's input counter restarts at 0.
- Tracks frames in flight through the core and reports frame completion from the core's output side.

---
 rtl/fft_sched_pkg.sv | 31 +++
 rtl/fft_frame_sched_pp_buffer.sv | 38 +++
 rtl/fft_frame_sched.sv | 185 ++++++++++++++++++
 tb/tb_fft_frame_sched.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_sched_pkg.sv
// Shared types and constants for the FFT frame scheduler: read-FSM encoding,
// frame geometry and the frames-in-flight bookkeeping helper.
package fft_sched_pkg;

    localparam int NALL_DEF = 6;
    localparam int FRAME    = 1 << NALL_DEF;
    localparam int FLY_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAPW  = 2'd1,
        ST_BURST = 2'd2
    } rd_state_e;

    // Frames-in-flight update: an issue and a done in the same cycle cancel,
    // the count saturates at both ends instead of wrapping.
    function automatic logic [FLY_W-1:0] fly_next(
        input logic [FLY_W-1:0] cur,
        input logic             issue,
        input logic             done
    );
        logic [FLY_W-1:0] res;
        case ({issue, done})
            2'b10:   res = (cur == {FLY_W{1'b1}}) ? cur : cur + {{(FLY_W-1){1'b0}}, 1'b1};
            2'b01:   res = (cur == {FLY_W{1'b0}}) ? cur : cur - {{(FLY_W-1){1'b0}}, 1'b1};
            default: res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fft_frame_sched_pp_buffer.sv
// Two-bank ping-pong sample store: synchronous write, registered read that
// holds its last value whenever no read is requested.
module pp_buffer #(
    parameter int DW = 32,
    parameter int AW = 7
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    // Write port: the bank bit is the address MSB
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: one-cycle registered read, value held between bursts
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= {DW{1'b0}};
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_frame_sched.sv
// Frame scheduler in front of a pipelined FFT core: collects a gappy sample
// stream into ping-pong banks and issues each full bank as one gap-separated burst.
module fft_frame_sched
    import fft_sched_pkg::*;
#(
    parameter int width  = 16,
    parameter int NALL   = NALL_DEF,
    parameter int GAP    = 1,
    parameter int MAXFLY = 7
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    flush,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [width-1:0] s_re,
    input  logic signed [width-1:0] s_im,
    output logic                    fft_din_en,
    output logic signed [width-1:0] fft_din_re,
    output logic signed [width-1:0] fft_din_im,
    input  logic                    fft_dout_en,
    input  logic [NALL-1:0]         fft_dout_cnt,
    output logic                    frame_done,
    output logic [FLY_W-1:0]        in_flight,
    output logic                    busy,
    output logic                    err_ovf
);

    localparam int GW = $clog2(GAP + 1);
    localparam logic [NALL-1:0] LAST_ADDR = {NALL{1'b1}};

    // write side
    logic [NALL-1:0]    r_wcnt;
    logic               r_wb;
    logic [1:0]         r_full;
    // read side
    rd_state_e          r_state;
    logic [NALL-1:0]    r_rcnt;
    logic               r_rb;
    logic [GW-1:0]      r_gap_cnt;
    logic               r_din_en;
    // completion side
    logic               r_frame_done;
    logic [FLY_W-1:0]   r_in_flight;
    logic               r_err_ovf;

    logic               w_wr_fire;
    logic               w_wr_last;
    logic               w_rd_act;
    logic               w_issue;
    logic               w_done;
    logic               w_start;
    logic [1:0]         w_full_set;
    logic [1:0]         w_full_clr;
    logic [1:0]         w_full_nxt;
    logic [2*width-1:0] w_rd_data;

    assign s_ready    = ~r_full[r_wb];
    assign w_wr_fire  = s_valid & s_ready & ~flush;
    assign w_wr_last  = w_wr_fire & (r_wcnt == LAST_ADDR);

    assign w_rd_act   = (r_state == ST_BURST) & ~flush;
    assign w_issue    = w_rd_act & (r_rcnt == LAST_ADDR);
    assign w_start    = (r_state == ST_IDLE) & r_full[r_rb]
                      & (r_gap_cnt == {GW{1'b0}})
                      & (r_in_flight < FLY_W'(MAXFLY));

    assign w_done     = fft_dout_en & (fft_dout_cnt == LAST_ADDR);

    // Fill and drain of different banks in the same cycle must both land
    assign w_full_set = {w_wr_last & r_wb, w_wr_last & ~r_wb};
    assign w_full_clr = {w_issue & r_rb, w_issue & ~r_rb};
    assign w_full_nxt = (r_full | w_full_set) & ~w_full_clr;

    pp_buffer #(
        .DW (2 * width),
        .AW (NALL + 1)
    ) u_buf (
        .i_clk   (clk),
        .i_rst_n (areset),
        .i_we    (w_wr_fire),
        .i_waddr ({r_wb, r_wcnt}),
        .i_wdata ({s_re, s_im}),
        .i_re    (w_rd_act),
        .i_raddr ({r_rb, r_rcnt}),
        .o_rdata (w_rd_data)
    );

    // Write-side fill counter, bank select and bank-full flags
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_wcnt <= {NALL{1'b0}};
            r_wb   <= 1'b0;
            r_full <= 2'b00;
        end else if (flush) begin
            r_wcnt <= {NALL{1'b0}};
            r_wb   <= 1'b0;
            r_full <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_last) begin
                r_wcnt <= {NALL{1'b0}};
                r_wb   <= ~r_wb;
            end else if (w_wr_fire) begin
                r_wcnt <= r_wcnt + {{(NALL-1){1'b0}}, 1'b1};
            end
        end
    end

    // Read FSM: idle until a full bank may go, stream it, then enforce the gap
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state   <= ST_IDLE;
            r_rcnt    <= {NALL{1'b0}};
            r_rb      <= 1'b0;
            r_gap_cnt <= GW'(GAP);
            r_din_en  <= 1'b0;
        end else if (flush) begin
            r_state   <= ST_GAPW;
            r_rcnt    <= {NALL{1'b0}};
            r_rb      <= 1'b0;
            r_gap_cnt <= GW'(GAP);
            r_din_en  <= 1'b0;
        end else begin
            r_din_en <= (r_state == ST_BURST);
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_BURST;
                        r_rcnt  <= {NALL{1'b0}};
                    end else if (r_gap_cnt != {GW{1'b0}}) begin
                        r_gap_cnt <= r_gap_cnt - {{(GW-1){1'b0}}, 1'b1};
                    end
                end
                ST_BURST: begin
                    if (r_rcnt == LAST_ADDR) begin
                        r_rcnt    <= {NALL{1'b0}};
                        r_rb      <= ~r_rb;
                        r_gap_cnt <= GW'(GAP);
                        r_state   <= ST_GAPW;
                    end else begin
                        r_rcnt <= r_rcnt + {{(NALL-1){1'b0}}, 1'b1};
                    end
                end
                ST_GAPW: begin
                    // the last gap cycle hands over to IDLE with the gap already done
                    if (r_gap_cnt <= {{(GW-1){1'b0}}, 1'b1}) begin
                        r_gap_cnt <= {GW{1'b0}};
                        r_state   <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - {{(GW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Completion tracking; flush leaves frames already in the core untouched
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_frame_done <= 1'b0;
            r_in_flight  <= {FLY_W{1'b0}};
            r_err_ovf    <= 1'b0;
        end else begin
            r_frame_done <= w_done;
            r_in_flight  <= fly_next(r_in_flight, w_issue, w_done);
            if (w_done && (r_in_flight == {FLY_W{1'b0}})) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    assign fft_din_en = r_din_en;
    assign fft_din_re = w_rd_data[2*width-1 -: width];
    assign fft_din_im = w_rd_data[width-1:0];
    assign frame_done = r_frame_done;
    assign in_flight  = r_in_flight;
    assign err_ovf    = r_err_ovf;
    assign busy       = (r_full != 2'b00) | (r_state == ST_BURST) | r_din_en
                      | (r_in_flight != {FLY_W{1'b0}});

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched with a fixed-latency FFT core model;
// a second instance with MAXFLY = 2 covers the in-flight hold-off.
module tb_fft_frame_sched;
    import fft_sched_pkg::*;

    localparam int W   = 16;
    localparam int LAT = 65;

    logic          clk = 1'b0;
    logic          areset;
    logic          flush;
    logic          s_valid;
    logic signed [W-1:0] s_re;
    logic signed [W-1:0] s_im;
    logic          s_ready;
    logic          fft_din_en;
    logic signed [W-1:0] fft_din_re;
    logic signed [W-1:0] fft_din_im;
    logic          fft_dout_en;
    logic [5:0]    fft_dout_cnt;
    logic          frame_done;
    logic [FLY_W-1:0] in_flight;
    logic          busy;
    logic          err_ovf;

    logic          d2_s_ready;
    logic          d2_din_en;
    logic signed [W-1:0] d2_din_re;
    logic signed [W-1:0] d2_din_im;
    logic          d2_frame_done;
    logic [FLY_W-1:0] d2_in_flight;
    logic          d2_busy;
    logic          d2_err_ovf;

    logic          core_on;
    logic          inj_mode;
    logic          inj_en;
    logic [5:0]    inj_cnt;
    logic [LAT-1:0] en_pipe;
    logic [5:0]    out_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run = 0;
    int hs_cnt = 0;
    int last_hs = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] out_q[$];
    int burst_q[$];
    int rise_q[$];

    always #5 clk = ~clk;

    fft_frame_sched #(.width(W), .NALL(6), .GAP(1), .MAXFLY(7)) dut (
        .clk(clk), .areset(areset), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
        .s_re(s_re), .s_im(s_im), .fft_din_en(fft_din_en), .fft_din_re(fft_din_re),
        .fft_din_im(fft_din_im), .fft_dout_en(fft_dout_en), .fft_dout_cnt(fft_dout_cnt),
        .frame_done(frame_done), .in_flight(in_flight), .busy(busy), .err_ovf(err_ovf)
    );

    fft_frame_sched #(.width(W), .NALL(6), .GAP(1), .MAXFLY(2)) dut2 (
        .clk(clk), .areset(areset), .flush(flush), .s_valid(s_valid), .s_ready(d2_s_ready),
        .s_re(s_re), .s_im(s_im), .fft_din_en(d2_din_en), .fft_din_re(d2_din_re),
        .fft_din_im(d2_din_im), .fft_dout_en(fft_dout_en), .fft_dout_cnt(fft_dout_cnt),
        .frame_done(d2_frame_done), .in_flight(d2_in_flight), .busy(d2_busy), .err_ovf(d2_err_ovf)
    );

    // Core model: enable delayed by LAT cycles, output index counts emitted samples
    always @(posedge clk or negedge areset) begin
        if (!areset) begin
            en_pipe <= '0;
            out_cnt <= 6'd0;
        end else begin
            en_pipe <= {en_pipe[LAT-2:0], fft_din_en & core_on};
            if (en_pipe[LAT-1]) out_cnt <= out_cnt + 6'd1;
        end
    end
    assign fft_dout_en  = inj_mode ? inj_en  : en_pipe[LAT-1];
    assign fft_dout_cnt = inj_mode ? inj_cnt : out_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (fft_din_en) begin
            if (run == 0) rise_q.push_back(cyc);
            out_q.push_back({fft_din_re, fft_din_im});
            run++;
        end else if (run != 0) begin
            burst_q.push_back(run);
            run = 0;
        end
    endtask

    task automatic drive_sample(input logic v);
        s_valid = v;
        s_re = W'($urandom);
        s_im = W'($urandom);
        if (v && s_ready && !flush) begin
            exp_q.push_back({s_re, s_im});
            hs_cnt++;
            last_hs = cyc + 1;
        end
    endtask

    task automatic clear_logs();
        exp_q.delete(); out_q.delete(); burst_q.delete(); rise_q.delete();
        run = 0; hs_cnt = 0;
    endtask

    task automatic do_reset();
        areset = 1'b0; flush = 1'b0; s_valid = 1'b0; s_re = '0; s_im = '0;
        inj_mode = 1'b0; inj_en = 1'b0; inj_cnt = 6'd0; core_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        areset = 1'b1;
        cyc = 0;
        clear_logs();
    endtask

    task automatic test_reset();
        areset = 1'b0; flush = 1'b0; s_valid = 1'b0; s_re = '0; s_im = '0;
        inj_mode = 1'b0; inj_en = 1'b0; inj_cnt = 6'd0; core_on = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        checks++; if (fft_din_en !== 1'b0) begin errors++; $display("FAIL reset_din_en: got %b expected 0", fft_din_en); end
        checks++; if (fft_din_re !== 16'sd0) begin errors++; $display("FAIL reset_din_re: got %0h expected 0", fft_din_re); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (in_flight !== 3'd0) begin errors++; $display("FAIL reset_in_flight: got %0d expected 0", in_flight); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL reset_err_ovf: got %b expected 0", err_ovf); end
    endtask

    task automatic test_stream();
        int t64 = -1;
        do_reset();
        for (int g = 0; g < 400 && hs_cnt < 128; g++) begin
            drive_sample(1'b1);
            if (hs_cnt == 64 && t64 < 0) t64 = last_hs;
            tick();
        end
        s_valid = 1'b0;
        repeat (200) tick();
        checks++; if (hs_cnt !== 128) begin errors++; $display("FAIL stream_accepted: got %0d expected 128", hs_cnt); end
        checks++; if (burst_q.size() !== 2) begin errors++; $display("FAIL stream_bursts: got %0d expected 2", burst_q.size()); end
        foreach (burst_q[i]) begin
            checks++; if (burst_q[i] !== 64) begin errors++; $display("FAIL stream_burst_len[%0d]: got %0d expected 64", i, burst_q[i]); end
        end
        if (rise_q.size() > 0) begin
            checks++; if (rise_q[0] !== t64 + 2) begin errors++; $display("FAIL stream_first_latency: got cycle %0d expected %0d", rise_q[0], t64 + 2); end
        end
        checks++; if (out_q.size() !== exp_q.size()) begin errors++; $display("FAIL stream_count: got %0d expected %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            checks++; if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, out_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_completion();
        int done_cnt = 0;
        int first_done = -1;
        int fly_at_done = -1;
        int fly_seq[$];
        logic [FLY_W-1:0] prev_fly = 3'd0;
        do_reset();
        for (int g = 0; g < 500; g++) begin
            drive_sample(hs_cnt < 128);
            tick();
            if (frame_done) begin
                done_cnt++;
                if (first_done < 0) begin first_done = cyc; fly_at_done = int'(in_flight); end
            end
            if (in_flight !== prev_fly) begin fly_seq.push_back(int'(in_flight)); prev_fly = in_flight; end
        end
        checks++; if (done_cnt !== 2) begin errors++; $display("FAIL done_pulses: got %0d expected 2", done_cnt); end
        if (rise_q.size() > 0) begin
            checks++; if (first_done !== rise_q[0] + 129) begin errors++; $display("FAIL done_latency: got cycle %0d expected %0d", first_done, rise_q[0] + 129); end
        end
        checks++; if (fly_at_done !== 1) begin errors++; $display("FAIL fly_issue_and_done: got %0d expected 1", fly_at_done); end
        checks++; if (fly_seq.size() !== 2) begin errors++; $display("FAIL fly_seq_len: got %0d expected 2", fly_seq.size()); end
        if (fly_seq.size() == 2) begin
            checks++; if (fly_seq[0] !== 1 || fly_seq[1] !== 0) begin errors++; $display("FAIL fly_seq: got %0d,%0d expected 1,0", fly_seq[0], fly_seq[1]); end
        end
        checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL completion_err: got %b expected 0", err_ovf); end
    endtask

    task automatic test_random();
        int bad_ready = 0;
        do_reset();
        for (int g = 0; g < 1000 && hs_cnt < 192; g++) begin
            if (!s_ready && !(hs_cnt % 64 == 0 && hs_cnt >= 128)) bad_ready++;
            drive_sample(logic'($urandom_range(0, 1)));
            tick();
        end
        s_valid = 1'b0;
        repeat (250) tick();
        checks++; if (hs_cnt !== 192) begin errors++; $display("FAIL random_accepted: got %0d expected 192", hs_cnt); end
        checks++; if (bad_ready !== 0) begin errors++; $display("FAIL random_ready_drop: got %0d expected 0", bad_ready); end
        checks++; if (burst_q.size() !== 3) begin errors++; $display("FAIL random_bursts: got %0d expected 3", burst_q.size()); end
        foreach (burst_q[i]) begin
            checks++; if (burst_q[i] !== 64) begin errors++; $display("FAIL random_burst_len[%0d]: got %0d expected 64", i, burst_q[i]); end
        end
        checks++; if (out_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_count: got %0d expected %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            checks++; if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_data[%0d]: got %h expected %h", i, out_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_maxfly();
        int hs2 = 0;
        int rises2 = 0;
        logic prev2 = 1'b0;
        do_reset();
        core_on = 1'b0;
        for (int g = 0; g < 700; g++) begin
            drive_sample(1'b1);
            if (d2_s_ready) hs2++;
            tick();
            if (d2_din_en && !prev2) rises2++;
            prev2 = d2_din_en;
        end
        s_valid = 1'b0;
        checks++; if (hs2 !== 256) begin errors++; $display("FAIL maxfly_accepted: got %0d expected 256", hs2); end
        checks++; if (rises2 !== 2) begin errors++; $display("FAIL maxfly_bursts: got %0d expected 2", rises2); end
        checks++; if (d2_s_ready !== 1'b0) begin errors++; $display("FAIL maxfly_s_ready: got %b expected 0", d2_s_ready); end
        checks++; if (d2_in_flight !== 3'd2) begin errors++; $display("FAIL maxfly_in_flight: got %0d expected 2", d2_in_flight); end
        checks++; if (d2_busy !== 1'b1) begin errors++; $display("FAIL maxfly_busy: got %b expected 1", d2_busy); end
    endtask

    task automatic test_flush();
        do_reset();
        core_on = 1'b0;
        for (int g = 0; g < 600 && out_q.size() < 94; g++) begin
            drive_sample(1'b1);
            tick();
        end
        checks++; if (out_q.size() !== 94) begin errors++; $display("FAIL flush_reach: got %0d expected 94", out_q.size()); end
        checks++; if (in_flight !== 3'd1) begin errors++; $display("FAIL flush_pre_fly: got %0d expected 1", in_flight); end
        s_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (fft_din_en !== 1'b0) begin errors++; $display("FAIL flush_din_en: got %b expected 0", fft_din_en); end
        checks++; if (in_flight !== 3'd1) begin errors++; $display("FAIL flush_fly: got %0d expected 1", in_flight); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL flush_s_ready: got %b expected 1", s_ready); end
        clear_logs();
        for (int g = 0; g < 300 && hs_cnt < 64; g++) begin
            drive_sample(1'b1);
            tick();
        end
        s_valid = 1'b0;
        repeat (150) tick();
        checks++; if (burst_q.size() !== 1) begin errors++; $display("FAIL flush_bursts: got %0d expected 1", burst_q.size()); end
        if (burst_q.size() > 0) begin
            checks++; if (burst_q[0] !== 64) begin errors++; $display("FAIL flush_burst_len: got %0d expected 64", burst_q[0]); end
        end
        checks++; if (out_q.size() !== exp_q.size()) begin errors++; $display("FAIL flush_count: got %0d expected %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            checks++; if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL flush_data[%0d]: got %h expected %h", i, out_q[i], exp_q[i]); end
        end
        checks++; if (in_flight !== 3'd2) begin errors++; $display("FAIL flush_post_fly: got %0d expected 2", in_flight); end
    endtask

    task automatic test_err_and_async_reset();
        do_reset();
        inj_mode = 1'b1; inj_en = 1'b1; inj_cnt = 6'd62;
        tick();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL err_cnt62_done: got %b expected 0", frame_done); end
        checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL err_cnt62: got %b expected 0", err_ovf); end
        inj_cnt = 6'd63;
        tick();
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL err_cnt63_done: got %b expected 1", frame_done); end
        checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", err_ovf); end
        checks++; if (in_flight !== 3'd0) begin errors++; $display("FAIL err_fly: got %0d expected 0", in_flight); end
        inj_en = 1'b0;
        repeat (5) tick();
        checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err_ovf); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL err_done_pulse: got %b expected 0", frame_done); end
        inj_mode = 1'b0;
        for (int g = 0; g < 300 && !fft_din_en; g++) begin
            drive_sample(1'b1);
            tick();
        end
        s_valid = 1'b0;
        checks++; if (fft_din_en !== 1'b1) begin errors++; $display("FAIL midburst_en: got %b expected 1", fft_din_en); end
        #2;
        areset = 1'b0;
        #1;
        checks++; if (fft_din_en !== 1'b0) begin errors++; $display("FAIL areset_din_en: got %b expected 0", fft_din_en); end
        checks++; if (fft_din_re !== 16'sd0 || fft_din_im !== 16'sd0) begin errors++; $display("FAIL areset_din_data: got %h/%h expected 0/0", fft_din_re, fft_din_im); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL areset_s_ready: got %b expected 1", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
        checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL areset_err: got %b expected 0", err_ovf); end
        checks++; if (in_flight !== 3'd0) begin errors++; $display("FAIL areset_fly: got %0d expected 0", in_flight); end
        areset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_completion();
        test_random();
        test_maxfly();
        test_flush();
        test_err_and_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
